// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// id_ex_pipe_reg : elastic ID/EX register for the dual-issue SPU datapath,
//                  main entry plus one skid entry, flush and stall counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe_reg #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 16,
  parameter int LANES  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [LANES-1:0]          up_lane_valid,
  input  logic [LANES*DATA_W-1:0]   up_ra,
  input  logic [LANES*DATA_W-1:0]   up_rb,
  input  logic [LANES*DATA_W-1:0]   up_rc,
  input  logic [LANES*DATA_W-1:0]   up_imm,
  input  logic [LANES*CTRL_W-1:0]   up_ctrl,
  input  logic [PC_W-1:0]           up_pc8,
  output logic                      dn_valid,
  input  logic                      dn_ready,
  output logic [LANES-1:0]          dn_lane_valid,
  output logic [LANES*DATA_W-1:0]   dn_ra,
  output logic [LANES*DATA_W-1:0]   dn_rb,
  output logic [LANES*DATA_W-1:0]   dn_rc,
  output logic [LANES*DATA_W-1:0]   dn_imm,
  output logic [LANES*CTRL_W-1:0]   dn_ctrl,
  output logic [PC_W-1:0]           dn_pc8,
  output logic [CNT_W-1:0]          stall_cycles
);

  typedef struct packed {
    logic [LANES-1:0]        lv;
    logic [LANES*DATA_W-1:0] ra;
    logic [LANES*DATA_W-1:0] rb;
    logic [LANES*DATA_W-1:0] rc;
    logic [LANES*DATA_W-1:0] imm;
    logic [LANES*CTRL_W-1:0] ctrl;
    logic [PC_W-1:0]         pc8;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  entry_t           r_m;
  entry_t           r_s;
  logic [CNT_W-1:0] r_stall;
  entry_t           w_up;
  logic             w_acc;
  logic             w_pop;

  assign w_up  = '{lv: up_lane_valid, ra: up_ra, rb: up_rb, rc: up_rc,
                   imm: up_imm, ctrl: up_ctrl, pc8: up_pc8};

  // Ready depends only on local state so no combinational path reaches decode.
  assign up_ready = !reset && (r_state != FULL);
  assign dn_valid = (r_state != EMPTY);
  assign w_acc    = up_valid && up_ready;
  assign w_pop    = dn_valid && dn_ready;

  assign dn_lane_valid = dn_valid ? r_m.lv : '0;
  assign dn_ra         = r_m.ra;
  assign dn_rb         = r_m.rb;
  assign dn_rc         = r_m.rc;
  assign dn_imm        = r_m.imm;
  assign dn_ctrl       = r_m.ctrl;
  assign dn_pc8        = r_m.pc8;
  assign stall_cycles  = r_stall;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_m     <= w_up;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_acc && w_pop) begin
            r_m <= w_up;
          end else if (w_acc) begin
            r_s     <= w_up;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_m     <= r_s;
            r_s     <= '0;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (dn_valid && !dn_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Elastic ID/EX pipeline register for the dual-issue SPU datapath. It carries the operands, immediate, control word and lane-valid of each issue lane (even/odd pipe), plus a shared PC+8, from decode/register-read into execute. A valid/ready handshake with a one-entry skid buffer lets execute stall without a combinational ready path back to decode. A synchronous flush turns the stage into a bubble on branch redirect. A saturating counter reports downstream stall cycles.

Parameters:
DATA_W, 128, width of each operand and immediate
PC_W, 32, width of PC+8
CTRL_W, 16, per-lane decoded control word width
LANES, 2, number of issue lanes (lane 0 = even pipe, lane 1 = odd pipe)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held entries
up_valid  input  1  decode presents a bundle
up_ready  output  1  stage can accept a bundle this cycle
up_lane_valid  input  LANES  per-lane instruction valid
up_ra, up_rb, up_rc, up_imm  input  LANES*DATA_W each  lane-packed operands/immediate; lane i at [i*DATA_W +: DATA_W]
up_ctrl  input  LANES*CTRL_W  lane-packed control words
up_pc8  input  PC_W  PC+8 of bundle
dn_valid  output  1  bundle available to execute
dn_ready  input  1  execute consumes bundle this cycle
dn_lane_valid  output  LANES  per-lane valid, gated by dn_valid
dn_ra, dn_rb, dn_rc, dn_imm  output  LANES*DATA_W each  held operands/immediate
dn_ctrl  output  LANES*CTRL_W  held control words
dn_pc8  output  PC_W  held PC+8
stall_cycles  output  CNT_W  saturating count of cycles with dn_valid=1 and dn_ready=0

Behaviour:
- Storage: main entry M (drives all dn_* outputs directly from flops) and skid entry S. State is EMPTY (M and S invalid), ONE (M valid, S invalid) or FULL (both valid).
- acc = up_valid & up_ready; pop = dn_valid & dn_ready.
- up_ready = !reset & (state != FULL). This is combinational from state only and never depends on dn_ready.
- dn_valid = (state != EMPTY). dn_lane_valid = M.lane_valid when dn_valid=1, else 0.
- EMPTY: on acc, load M and go to ONE.
- ONE: acc&pop loads M with new bundle and stays in ONE. acc&!pop loads S and goes to FULL. !acc&pop goes to EMPTY. Otherwise M is held.
- FULL: up_ready=0. On pop, M<=S, S is invalidated, go to ONE. Otherwise hold.
- Latency: a bundle accepted in cycle t is on dn_* in cycle t+1 when M was free or popped in t. Order is strictly FIFO and nothing is dropped or duplicated.
- dn_* outputs stay stable while dn_valid=1 and dn_ready=0.
- Flush: next state is EMPTY. M and S payload, lane_valid and ctrl are zeroed. A bundle accepted in the flush cycle is discarded. dn_valid=0 in cycle t+1. up_ready is unaffected in the flush cycle.
- Reset (priority over flush): state EMPTY, all dn_* zero, dn_valid=0, stall_cycles=0, up_ready=0 while reset is asserted. Reset mid-operation discards M and S.
- stall_cycles increments by 1 each cycle with dn_valid & !dn_ready and saturates at 2^CNT_W-1. It is cleared only by reset; flush does not clear it.
- A lane with up_lane_valid=0 is still carried (payload stored); only its valid bit is 0.

Test Plan:
- Reset, then drive up_valid=1 with up_pc8=0x100, lane0 ra=128'h1, dn_ready=1 -> dn_valid=1 next cycle, dn_pc8=0x100, dn_ra[127:0]=1. All outputs are 0 during reset.
- Stream 8 bundles, pc8=0x0..0x1C step 4, dn_ready=1 constant -> one bundle per cycle, 1-cycle latency, up_ready stays 1.
- Bundles pc8=0x10, 0x14, 0x18 with dn_ready=0 from the cycle 0x10 appears -> 0x14 goes to skid, up_ready=0, 0x18 is held off. Release dn_ready -> dn_pc8 sequence is 0x10, 0x14, 0x18 with no loss. stall_cycles equals the number of stalled cycles.
- Stage FULL (pc8=0x20, 0x24), assert flush with up_valid=1, pc8=0x28 -> next cycle dn_valid=0, dn_lane_valid=0, dn_ctrl=0, up_ready=1, and 0x28 never appears.
- Hold dn_valid=1, dn_ready=0 with CNT_W=4 for 20 cycles -> stall_cycles saturates at 15. A following flush leaves it at 15; reset clears it to 0.
- Send a bundle with up_lane_valid=2'b10 -> dn_lane_valid=2'b10 and lane0 payload is still passed through unchanged.
